deck_shuffler: RTL and testbench

Fills the 52-entry deck memory with a shuffled deck that the card-adding datapath later reads card by card. On a start request it writes an ordered deck, then performs an in-place Fisher-Yates shuffle driven by a free-running LFSR. It uses the deck memory's write port and a synchronous read port, and signals completion to the game FSM before any card is dealt.

---
 rtl/deck_shuffler_if.sv | 22 ++
 rtl/deck_shuffler.sv | 189 ++++++++++++++++++
 tb/tb_deck_shuffler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/deck_shuffler_if.sv
// Deck memory bus between deck_shuffler and its environment.
// The master modport is the shuffler side: it receives the start request and
// memory read data, and drives the shared address, write port and status flags.
interface deck_shuffler_if;
   logic       i_Start;
   logic [3:0] i_RdData;
   logic [5:0] o_Address;
   logic [3:0] o_WrData;
   logic       o_WrEn;
   logic       o_Busy;
   logic       o_Done;

   modport master (
      input  i_Start, i_RdData,
      output o_Address, o_WrData, o_WrEn, o_Busy, o_Done
   );

   modport slave (
      output i_Start, i_RdData,
      input  o_Address, o_WrData, o_WrEn, o_Busy, o_Done
   );
endinterface

// File: rtl/deck_shuffler.sv
// deck_shuffler: writes an ordered deck (card code = k mod 13) into the deck
// memory, then shuffles it in place with Fisher-Yates. Each swap index is drawn
// from a free-running 16-bit LFSR by rejection sampling.
//
// Build option: define DECK_SHUFFLE_EN to build the shuffle stage. Without it,
// FILL goes straight to DONE and leaves an ordered deck for deterministic tests.
//
// The memory is one shared address with a write strobe and a synchronous read:
// read data for an address is valid one cycle after that address is presented.
module deck_shuffler #(
   parameter int unsigned DECK_SIZE = 52,      // entries written and shuffled, at most 64
   parameter logic [15:0] LFSR_SEED = 16'hACE1 // nonzero LFSR reset value
) (
   input logic             i_Clock,
   input logic             i_Reset_n,
   deck_shuffler_if.master bus
);

   localparam logic [5:0] LAST_K    = 6'(DECK_SIZE - 1);
   localparam logic [3:0] LAST_CODE = 4'd12;   // King; the fill code wraps after it

`ifdef DECK_SHUFFLE_EN
   typedef enum logic [3:0] {
      S_IDLE, S_FILL, S_PICK, S_RD_I, S_RD_J, S_CAP, S_WR_I, S_WR_J, S_DONE
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_FILL, S_DONE
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [5:0]  k_q, k_d;        // fill address
   logic [3:0]  code_q, code_d;  // fill data, kept as a mod-13 counter

`ifdef DECK_SHUFFLE_EN
   logic [5:0]  i_q, i_d;        // upper swap index, counts down to 1
   logic [5:0]  j_q, j_d;        // accepted random index, 0..i
   logic [3:0]  di_q, di_d;      // card read from i
   logic [3:0]  dj_q, dj_d;      // card read from j
   logic [5:0]  r_w;             // current random draw

   assign r_w = lfsr_q[5:0];
`else
   // Read data has no consumer when the shuffle stage is not built.
   logic unused_rd_data;
   assign unused_rd_data = ^bus.i_RdData;
`endif

   // Fibonacci LFSR, taps 16,14,13,11; it advances in every state so the
   // arrival time of i_Start decides the shuffle.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // State register.
   // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic.
   // NOTE: each combinational block assigns defaults first so no path leaves a signal unassigned (no latches).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.i_Start) state_d = S_FILL;
`ifdef DECK_SHUFFLE_EN
         S_FILL: if (k_q == LAST_K) state_d = S_PICK;
         S_PICK: if (r_w <= i_q) state_d = S_RD_I;
         S_RD_I: state_d = S_RD_J;
         S_RD_J: state_d = S_CAP;
         S_CAP:  state_d = S_WR_I;
         S_WR_I: state_d = S_WR_J;
         S_WR_J: state_d = (i_q == 6'd1) ? S_DONE : S_PICK;
`else
         S_FILL: if (k_q == LAST_K) state_d = S_DONE;
`endif
         S_DONE: if (bus.i_Start) state_d = S_FILL;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state; IDLE decodes to all zeros.
   always_comb begin
      bus.o_Address = '0;
      bus.o_WrData  = '0;
      bus.o_WrEn    = 1'b0;
      bus.o_Busy    = 1'b0;
      bus.o_Done    = 1'b0;
      case (state_q)
         S_FILL: begin
            bus.o_Address = k_q;
            bus.o_WrData  = code_q;
            bus.o_WrEn    = 1'b1;
            bus.o_Busy    = 1'b1;
         end
`ifdef DECK_SHUFFLE_EN
         S_PICK, S_CAP: begin
            bus.o_Busy    = 1'b1;
         end
         S_RD_I: begin
            bus.o_Address = i_q;
            bus.o_Busy    = 1'b1;
         end
         S_RD_J: begin
            bus.o_Address = j_q;
            bus.o_Busy    = 1'b1;
         end
         S_WR_I: begin
            bus.o_Address = i_q;
            bus.o_WrData  = dj_q;
            bus.o_WrEn    = 1'b1;
            bus.o_Busy    = 1'b1;
         end
         S_WR_J: begin
            bus.o_Address = j_q;
            bus.o_WrData  = di_q;
            bus.o_WrEn    = 1'b1;
            bus.o_Busy    = 1'b1;
         end
`endif
         S_DONE: begin
            bus.o_Done    = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath next values: fill counters, swap indices and captured cards.
   always_comb begin
      k_d    = k_q;
      code_d = code_q;
`ifdef DECK_SHUFFLE_EN
      i_d    = i_q;
      j_d    = j_q;
      di_d   = di_q;
      dj_d   = dj_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.i_Start) begin
               k_d    = '0;
               code_d = '0;
            end
         end
         S_FILL: begin
            k_d    = k_q + 6'd1;
            code_d = (code_q == LAST_CODE) ? 4'd0 : code_q + 4'd1;
`ifdef DECK_SHUFFLE_EN
            i_d    = LAST_K;
`endif
         end
`ifdef DECK_SHUFFLE_EN
         S_PICK: if (r_w <= i_q) j_d = r_w;
         S_RD_J: di_d = bus.i_RdData;   // data for address i, presented in RD_I
         S_CAP:  dj_d = bus.i_RdData;   // data for address j, presented in RD_J
         S_WR_J: i_d  = i_q - 6'd1;
`endif
         default: ;
      endcase
   end

   // Datapath and LFSR registers.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         lfsr_q <= LFSR_SEED;
         k_q    <= '0;
         code_q <= '0;
`ifdef DECK_SHUFFLE_EN
         i_q    <= '0;
         j_q    <= '0;
         di_q   <= '0;
         dj_q   <= '0;
`endif
      end else begin
         lfsr_q <= lfsr_d;
         k_q    <= k_d;
         code_q <= code_d;
`ifdef DECK_SHUFFLE_EN
         i_q    <= i_d;
         j_q    <= j_d;
         di_q   <= di_d;
         dj_q   <= dj_d;
`endif
      end
   end

endmodule

// File: tb/tb_deck_shuffler.sv
// Self-checking bench for deck_shuffler with a behavioural deck memory.
// The reference model derives the final deck and completion time from the
// start edge: ordered fill, then (with DECK_SHUFFLE_EN) Fisher-Yates driven
// by the LFSR sequence counted from reset release.
module tb_deck_shuffler;

   localparam int          DECK  = 52;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int          LIMIT = 20000;
`ifdef DECK_SHUFFLE_EN
   localparam bit SHUF = 1'b1;
`else
   localparam bit SHUF = 1'b0;
`endif
   localparam int EXP_WRITES = SHUF ? DECK + 2 * (DECK - 1) : DECK;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   deck_shuffler_if bus ();

   deck_shuffler #(.DECK_SIZE(DECK), .LFSR_SEED(SEED)) dut (
      .i_Clock   (clk),
      .i_Reset_n (rst_n),
      .bus       (bus)
   );

   // Deck memory: write on the edge, registered read.
   logic [3:0] mem [0:63];
   logic [3:0] rd_q = 4'd0;
   int         wr_total = 0;
   always @(posedge clk) begin
      if (bus.o_WrEn) begin
         mem[bus.o_Address] <= bus.o_WrData;
         wr_total <= wr_total + 1;
      end
      rd_q <= mem[bus.o_Address];
   end
   assign bus.i_RdData = rd_q;

   // Clock edges since the last reset release; edge n leaves the LFSR at step n.
   int edge_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Reference deck and the number of edges from the start-sampling edge s
   // until o_Done is high.
   logic [3:0] model [0:DECK-1];
   task automatic predict(input int s, output int ncyc);
      logic [15:0] v;
      logic [3:0]  tmp;
      int          t, j;
      for (int k = 0; k < DECK; k++) model[k] = 4'(k % 13);
      ncyc = DECK;
      if (SHUF) begin
         v = SEED;
         for (int n = 0; n < s + DECK; n++) v = lfsr_step(v);
         t = s + DECK;
         for (int i = DECK - 1; i >= 1; i--) begin
            while (int'(v[5:0]) > i) begin
               v = lfsr_step(v);
               t++;
            end
            j        = int'(v[5:0]);
            tmp      = model[i];
            model[i] = model[j];
            model[j] = tmp;
            for (int n = 0; n < 6; n++) v = lfsr_step(v);
            t += 6;
         end
         ncyc = t - s;
      end
   endtask

   task automatic do_reset(input int wait_cycles);
      @(negedge clk);
      rst_n       = 1'b0;
      bus.i_Start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (wait_cycles) @(negedge clk);
   endtask

   // One shuffle request with two ignored start pulses while busy.
   task automatic run(input string tag, input int pulse_a, input int pulse_b);
      int s, w0, cyc, exp_cyc, bad_idle, bad_busy, bad_deck, bad_hist, diff;
      int hist [0:12];
      @(negedge clk);
      bus.i_Start = 1'b1;
      @(negedge clk);
      bus.i_Start = 1'b0;
      s  = edge_cnt;
      w0 = wr_total;
      check({tag, "/accept_busy_done"}, {30'd0, bus.o_Busy, bus.o_Done}, 32'b10);
      predict(s, exp_cyc);
      cyc = 0; bad_idle = 0; bad_busy = 0;
      while (!bus.o_Done && cyc < LIMIT) begin
         if (!bus.o_WrEn && bus.o_WrData != 4'd0) bad_idle++;
         if (!bus.o_Busy) bad_busy++;
         bus.i_Start = (cyc == pulse_a || cyc == pulse_b);
         @(negedge clk);
         cyc++;
      end
      bus.i_Start = 1'b0;
      check({tag, "/cycles_to_done"}, cyc, exp_cyc);
      check({tag, "/write_count"}, wr_total - w0, EXP_WRITES);
      check({tag, "/wrdata_zero_when_idle"}, bad_idle, 0);
      check({tag, "/busy_while_running"}, bad_busy, 0);
      check({tag, "/done_busy_after"}, {30'd0, bus.o_Busy, bus.o_Done}, 32'b01);
      bad_deck = 0; diff = 0; bad_hist = 0;
      for (int c = 0; c < 13; c++) hist[c] = 0;
      for (int k = 0; k < DECK; k++) begin
         if (mem[k] !== model[k]) bad_deck++;
         if (mem[k] != 4'(k % 13)) diff++;
         if (mem[k] < 4'd13) hist[mem[k]]++;
         else bad_hist++;
      end
      for (int c = 0; c < 13; c++) if (hist[c] != 4) bad_hist++;
      check({tag, "/deck_vs_model"}, bad_deck, 0);
      check({tag, "/histogram"}, bad_hist, 0);
      check({tag, "/differs_from_ordered"}, 32'(diff != 0), 32'(SHUF));
   endtask

   logic [3:0] deck_a [0:DECK-1];

   initial begin
      int diff, cyc, target;
      bus.i_Start = 1'b0;

      // Reset state.
      #1;
      check("reset/outputs_held", {25'd0, bus.o_Address, bus.o_WrEn, bus.o_Busy, bus.o_Done},
            32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset/outputs_released",
            {21'd0, bus.o_Address, bus.o_WrData, bus.o_WrEn, bus.o_Busy, bus.o_Done}, 32'd0);
      @(posedge clk);
      #1;
      check("reset/lfsr_first_step", dut.lfsr_q, lfsr_step(SEED));
      check("reset/lfsr_moved", 32'(dut.lfsr_q != SEED), 32'd1);

      // Basic run, then a reshuffle straight from DONE.
      run("first", 5, SHUF ? 100 : 40);
      run("reshuffle", 30, SHUF ? 200 : 50);

      // Seed dependence on the start cycle after reset.
      do_reset(8);
      run("seed_a", -1, -1);
      for (int k = 0; k < DECK; k++) deck_a[k] = mem[k];
      do_reset(9);
      run("seed_b", -1, -1);
      diff = 0;
      for (int k = 0; k < DECK; k++) if (mem[k] !== deck_a[k]) diff++;
      check("seed/later_start_differs", 32'(diff != 0), 32'(SHUF));
      do_reset(8);
      run("seed_c", -1, -1);
      diff = 0;
      for (int k = 0; k < DECK; k++) if (mem[k] !== deck_a[k]) diff++;
      check("seed/same_start_identical", diff, 0);

      // Randomized start times and ignored busy-time start pulses.
      for (int n = 0; n < 3; n++) begin
         do_reset(int'($urandom_range(0, 30)));
         run($sformatf("rand%0d", n), int'($urandom_range(1, 45)),
             SHUF ? int'($urandom_range(60, 350)) : int'($urandom_range(1, 50)));
      end

      // Reset during a write cycle: a swap write when shuffling, a fill write otherwise.
      do_reset(3);
      @(negedge clk);
      bus.i_Start = 1'b1;
      @(negedge clk);
      bus.i_Start = 1'b0;
      target = SHUF ? DECK : 20;
      cyc = 0;
      while (!(cyc >= target && bus.o_WrEn) && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check("midreset/reached_write", 32'(cyc < LIMIT), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midreset/wren_busy_done_low", {29'd0, bus.o_WrEn, bus.o_Busy, bus.o_Done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midreset/done_stays_low", {31'd0, bus.o_Done}, 32'd0);
      run("after_midreset", 12, SHUF ? 150 : 45);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
